// File: rtl/fifo_sync.sv
// Parametrised single-clock FIFO: inferred RAM, registered read data, occupancy count,
// almost-full/almost-empty flags and overflow/underflow pulses. Define FIFO_SYNC_FWFT_EN for first-word-fall-through.
module fifo_sync #(
    parameter int WIDTH         = 36,
    parameter int DEPTH_LOG2    = 9,
    parameter int AFULL_THRESH  = (2 ** DEPTH_LOG2) - 4,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [WIDTH-1:0]      DI,
    input  logic                  WREN,
    output logic                  FULL,
    output logic                  ALMOST_FULL,
    output logic                  WRERR,
    output logic [WIDTH-1:0]      DO,
    input  logic                  RDEN,
    output logic                  EMPTY,
    output logic                  ALMOST_EMPTY,
    output logic                  RDERR,
    output logic [DEPTH_LOG2:0]   COUNT
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr_reg;
    logic [DEPTH_LOG2-1:0] rptr_reg;
    // occ_reg counts words held in the RAM itself (excludes the DO word in FWFT mode)
    logic [DEPTH_LOG2:0]   occ_reg;
    logic [DEPTH_LOG2:0]   occ_next;
    logic [WIDTH-1:0]      do_reg;
    logic                  wrerr_reg;
    logic                  rderr_reg;
    logic                  full_w;
    logic                  empty_w;
    logic [DEPTH_LOG2:0]   count_w;
    logic                  wr_ok;
    logic                  rd_ok;
    logic                  ram_rd;

    assign full_w = (occ_reg == DEPTH_CNT);
    assign wr_ok  = WREN && !full_w;

`ifdef FIFO_SYNC_FWFT_EN
    logic do_valid_reg;

    assign empty_w = !do_valid_reg;
    assign count_w = occ_reg + {{DEPTH_LOG2{1'b0}}, do_valid_reg};
    assign rd_ok   = RDEN && do_valid_reg;
    // Refill the output register whenever it is vacant or being consumed this edge
    assign ram_rd  = (occ_reg != '0) && (!do_valid_reg || rd_ok);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            do_valid_reg <= 1'b0;
        end else if (ram_rd) begin
            do_valid_reg <= 1'b1;
        end else if (rd_ok) begin
            do_valid_reg <= 1'b0;
        end
    end
`else
    assign empty_w = (occ_reg == '0);
    assign count_w = occ_reg;
    assign rd_ok   = RDEN && !empty_w;
    assign ram_rd  = rd_ok;
`endif

    always_comb begin
        occ_next = occ_reg;
        case ({wr_ok, ram_rd})
            2'b10:   occ_next = occ_reg + CNT_ONE;
            2'b01:   occ_next = occ_reg - CNT_ONE;
            default: occ_next = occ_reg;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (wr_ok) begin
            mem[wptr_reg] <= DI;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            occ_reg   <= '0;
            do_reg    <= '0;
            wrerr_reg <= 1'b0;
            rderr_reg <= 1'b0;
        end else begin
            if (wr_ok) begin
                wptr_reg <= wptr_reg + PTR_ONE;
            end
            if (ram_rd) begin
                rptr_reg <= rptr_reg + PTR_ONE;
                do_reg   <= mem[rptr_reg];
            end
            occ_reg   <= occ_next;
            wrerr_reg <= WREN && full_w;
            rderr_reg <= RDEN && empty_w;
        end
    end

    assign FULL         = full_w;
    assign EMPTY        = empty_w;
    assign COUNT        = count_w;
    assign ALMOST_FULL  = (int'(count_w) >= AFULL_THRESH);
    assign ALMOST_EMPTY = (int'(count_w) <= AEMPTY_THRESH);
    assign WRERR        = wrerr_reg;
    assign RDERR        = rderr_reg;
    assign DO           = do_reg;

endmodule

// File: tb/tb_fifo_sync.sv
// Directed self-checking bench for fifo_sync at DEPTH=4, AFULL=3, AEMPTY=1.
module tb_fifo_sync;

    localparam int W = 16;
    localparam int L = 2;

    logic         CLK = 1'b0;
    logic         RST_N = 1'b0;
    logic [W-1:0] DI = '0;
    logic         WREN = 1'b0;
    logic         RDEN = 1'b0;
    logic         FULL, ALMOST_FULL, WRERR, EMPTY, ALMOST_EMPTY, RDERR;
    logic [W-1:0] DO;
    logic [L:0]   COUNT;

    int checks = 0;
    int fails  = 0;

    always #5 CLK = ~CLK;

    fifo_sync #(
        .WIDTH(W), .DEPTH_LOG2(L), .AFULL_THRESH(3), .AEMPTY_THRESH(1)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .DI(DI), .WREN(WREN), .FULL(FULL),
        .ALMOST_FULL(ALMOST_FULL), .WRERR(WRERR), .DO(DO), .RDEN(RDEN),
        .EMPTY(EMPTY), .ALMOST_EMPTY(ALMOST_EMPTY), .RDERR(RDERR), .COUNT(COUNT)
    );

    // {FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY, WRERR, RDERR, COUNT[2:0]}
    wire [8:0] status = {FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY, WRERR, RDERR, COUNT};

    function automatic logic [8:0] flags(input int cnt, input logic we, input logic re);
        return {cnt == 4, cnt == 0, cnt >= 3, cnt <= 1, we, re, 3'(cnt)};
    endfunction

    task automatic cycle(input logic we, input logic re, input logic [W-1:0] d);
        WREN = we;
        RDEN = re;
        DI   = d;
        @(posedge CLK);
        #1;
        WREN = 1'b0;
        RDEN = 1'b0;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        #12;
        checks++;
        if (status !== flags(0, 0, 0)) begin
            $display("FAIL reset_status got %b want %b", status, flags(0, 0, 0));
            fails++;
        end
        checks++;
        if (DO !== '0) begin
            $display("FAIL reset_do got %h want 0", DO);
            fails++;
        end
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
    endtask

`ifndef FIFO_SYNC_FWFT_EN
    task automatic test_fill_drain();
        for (int i = 1; i <= 4; i++) begin
            cycle(1'b1, 1'b0, W'(i));
            checks++;
            if (status !== flags(i, 0, 0)) begin
                $display("FAIL fill_status n=%0d got %b want %b", i, status, flags(i, 0, 0));
                fails++;
            end
        end
        cycle(1'b1, 1'b0, 16'h0005);
        checks++;
        if (status !== flags(4, 1, 0)) begin
            $display("FAIL overflow_status got %b want %b", status, flags(4, 1, 0));
            fails++;
        end
        cycle(1'b0, 1'b0, '0);
        checks++;
        if (status !== flags(4, 0, 0)) begin
            $display("FAIL wrerr_clear got %b want %b", status, flags(4, 0, 0));
            fails++;
        end
        for (int i = 1; i <= 4; i++) begin
            cycle(1'b0, 1'b1, '0);
            checks++;
            if (DO !== W'(i)) begin
                $display("FAIL drain_data n=%0d got %h want %h", i, DO, W'(i));
                fails++;
            end
            checks++;
            if (status !== flags(4 - i, 0, 0)) begin
                $display("FAIL drain_status n=%0d got %b want %b", i, status, flags(4 - i, 0, 0));
                fails++;
            end
        end
    endtask

    task automatic test_underflow();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, '0);
            checks++;
            if (status !== flags(0, 0, 1) || DO !== 16'h0004) begin
                $display("FAIL underflow n=%0d got %b/%h want %b/0004", i, status, DO, flags(0, 0, 1));
                fails++;
            end
        end
        cycle(1'b0, 1'b0, '0);
        checks++;
        if (status !== flags(0, 0, 0)) begin
            $display("FAIL rderr_clear got %b want %b", status, flags(0, 0, 0));
            fails++;
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, W'(16'h0010 + i));
        cycle(1'b1, 1'b1, 16'h0099);
        checks++;
        if (status !== flags(3, 1, 0) || DO !== 16'h0010) begin
            $display("FAIL full_rw got %b/%h want %b/0010", status, DO, flags(3, 1, 0));
            fails++;
        end
        for (int i = 1; i <= 3; i++) begin
            cycle(1'b0, 1'b1, '0);
            checks++;
            if (DO !== W'(16'h0010 + i)) begin
                $display("FAIL full_rw_drain n=%0d got %h want %h", i, DO, W'(16'h0010 + i));
                fails++;
            end
        end
        cycle(1'b1, 1'b1, 16'h0077);
        checks++;
        if (status !== flags(1, 0, 1) || DO !== 16'h0013) begin
            $display("FAIL empty_rw got %b/%h want %b/0013", status, DO, flags(1, 0, 1));
            fails++;
        end
        cycle(1'b0, 1'b1, '0);
        checks++;
        if (status !== flags(0, 0, 0) || DO !== 16'h0077) begin
            $display("FAIL empty_rw_read got %b/%h want %b/0077", status, DO, flags(0, 0, 0));
            fails++;
        end
    endtask

    task automatic test_async_reset();
        cycle(1'b1, 1'b0, 16'h00AA);
        cycle(1'b1, 1'b0, 16'h00BB);
        cycle(1'b0, 1'b1, '0);
        checks++;
        if (status !== flags(1, 0, 0) || DO !== 16'h00AA) begin
            $display("FAIL pre_reset got %b/%h want %b/00aa", status, DO, flags(1, 0, 0));
            fails++;
        end
        #2;
        RST_N = 1'b0;
        #1;
        checks++;
        if (status !== flags(0, 0, 0) || DO !== '0) begin
            $display("FAIL async_reset got %b/%h want %b/0000", status, DO, flags(0, 0, 0));
            fails++;
        end
        #1;
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        cycle(1'b1, 1'b0, 16'h0055);
        cycle(1'b0, 1'b1, '0);
        checks++;
        if (status !== flags(0, 0, 0) || DO !== 16'h0055) begin
            $display("FAIL post_reset got %b/%h want %b/0055", status, DO, flags(0, 0, 0));
            fails++;
        end
    endtask

    task automatic test_stress();
        logic [W-1:0] q[$];
        logic [W-1:0] exp_do;
        logic [W-1:0] d;
        logic         we, re, ew, er;
        int           cnt;
        exp_do = 16'h0055;
        for (int i = 0; i < 1000; i++) begin
            // alternate fill-biased and drain-biased phases so both boundaries are hit
            we  = ($urandom_range(0, 99) < (((i / 40) % 2 == 0) ? 70 : 30));
            re  = ($urandom_range(0, 99) < (((i / 40) % 2 == 0) ? 30 : 70));
            d   = W'($urandom);
            cnt = q.size();
            ew  = we && (cnt == 4);
            er  = re && (cnt == 0);
            if (re && cnt > 0) exp_do = q.pop_front();
            if (we && cnt < 4) q.push_back(d);
            cycle(we, re, d);
            checks++;
            if (status !== flags(q.size(), ew, er) || DO !== exp_do) begin
                $display("FAIL stress cyc=%0d got %b/%h want %b/%h", i, status, DO,
                         flags(q.size(), ew, er), exp_do);
                fails++;
            end
        end
    endtask
`else
    task automatic test_fwft();
        cycle(1'b1, 1'b0, 16'h0ABC);
        checks++;
        if (EMPTY !== 1'b1 || COUNT !== 3'd1) begin
            $display("FAIL fwft_write got empty=%b count=%0d want 1/1", EMPTY, COUNT);
            fails++;
        end
        cycle(1'b0, 1'b0, '0);
        checks++;
        if (EMPTY !== 1'b0 || DO !== 16'h0ABC || COUNT !== 3'd1) begin
            $display("FAIL fwft_fall got empty=%b do=%h count=%0d want 0/0abc/1", EMPTY, DO, COUNT);
            fails++;
        end
        cycle(1'b0, 1'b1, '0);
        checks++;
        if (EMPTY !== 1'b1 || COUNT !== 3'd0 || RDERR !== 1'b0) begin
            $display("FAIL fwft_read got empty=%b count=%0d rderr=%b want 1/0/0", EMPTY, COUNT, RDERR);
            fails++;
        end
        for (int i = 1; i <= 3; i++) cycle(1'b1, 1'b0, W'(i));
        cycle(1'b0, 1'b0, '0);
        for (int i = 1; i <= 3; i++) begin
            checks++;
            if (EMPTY !== 1'b0 || DO !== W'(i) || COUNT !== 3'(4 - i)) begin
                $display("FAIL fwft_b2b n=%0d got do=%h count=%0d want %h/%0d", i, DO, COUNT, W'(i), 4 - i);
                fails++;
            end
            cycle(1'b0, 1'b1, '0);
        end
        checks++;
        if (EMPTY !== 1'b1 || COUNT !== 3'd0) begin
            $display("FAIL fwft_drained got empty=%b count=%0d want 1/0", EMPTY, COUNT);
            fails++;
        end
    endtask
`endif

    initial begin
        test_reset();
`ifndef FIFO_SYNC_FWFT_EN
        test_fill_drain();
        test_underflow();
        test_simultaneous();
        test_async_reset();
        test_stress();
`else
        test_fwft();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
